// File: rtl/coord_frame_assembler_if.sv
// Character-in / frame-out bundle between the digit classifier, the frame
// assembler and the flight-command logic.
interface coord_frame_assembler_if #(
  parameter int NUM_COORDS = 3,
  parameter int COORD_W    = 10
);
  logic                          char_valid;
  logic [7:0]                    num;
  logic [1:0]                    coords_state;
  logic [NUM_COORDS*COORD_W-1:0] coords;
  logic                          coords_valid;
  logic                          frame_error;
  logic                          busy;

  modport master (
    output char_valid, num, coords_state,
    input  coords, coords_valid, frame_error, busy
  );

  modport slave (
    input  char_valid, num, coords_state,
    output coords, coords_valid, frame_error, busy
  );
endinterface

// File: rtl/coord_frame_assembler.sv
// Builds "S<d>,<d>,...E" character runs into a frame of NUM_COORDS unsigned
// coordinates; emits a one-cycle valid pulse on good frames, an error pulse otherwise.
module coord_frame_assembler #(
  parameter int NUM_COORDS = 3,
  parameter int COORD_W    = 10,
  parameter int MAX_DIGITS = 3
) (
  input logic                    clock,
  input logic                    reset,
  coord_frame_assembler_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int IDX_W = $clog2(NUM_COORDS + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  localparam logic [1:0] CLS_NULL  = 2'b00;
  localparam logic [1:0] CLS_START = 2'b01;
  localparam logic [1:0] CLS_END   = 2'b10;
  localparam logic [1:0] CLS_NUM   = 2'b11;

  logic [0:0]                    r_state;
  logic [COORD_W-1:0]            r_acc;
  logic [CNT_W-1:0]              r_digit_cnt;
  logic [IDX_W-1:0]              r_idx;
  logic [COORD_W-1:0]            r_slots [NUM_COORDS];
  logic [NUM_COORDS*COORD_W-1:0] r_coords;
  logic                          r_valid;
  logic                          r_err;

  logic [COORD_W-1:0]            w_digit;
  logic [COORD_W-1:0]            w_acc_next;
  logic                          w_have_digits;
  logic                          w_idx_room;
  logic [IDX_W-1:0]              w_end_cnt;
  logic                          w_end_ok;
  logic [NUM_COORDS*COORD_W-1:0] w_frame;

  always_comb begin
    w_digit       = {{(COORD_W-4){1'b0}}, bus.num[3:0]};
    w_acc_next    = (r_acc << 3) + (r_acc << 1) + w_digit;
    w_have_digits = (r_digit_cnt != '0);
    w_idx_room    = (r_idx < IDX_W'(NUM_COORDS));
    w_end_cnt     = w_have_digits ? (r_idx + IDX_W'(1)) : r_idx;
    // END succeeds only if the pending flush has room and completes the frame
    w_end_ok      = (!w_have_digits || w_idx_room) && (w_end_cnt == IDX_W'(NUM_COORDS));
    w_frame       = '0;
    for (int unsigned i = 0; i < NUM_COORDS; i++) begin
      if (w_have_digits && (r_idx == IDX_W'(i)))
        w_frame[i*COORD_W +: COORD_W] = r_acc;
      else
        w_frame[i*COORD_W +: COORD_W] = r_slots[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_digit_cnt <= '0;
      r_idx       <= '0;
      r_coords    <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      for (int unsigned i = 0; i < NUM_COORDS; i++) r_slots[i] <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (bus.char_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (bus.coords_state == CLS_START) begin
              r_state     <= ST_RECV;
              r_acc       <= '0;
              r_digit_cnt <= '0;
              r_idx       <= '0;
            end
          end
          default: begin
            case (bus.coords_state)
              CLS_START: begin
                r_err       <= 1'b1;
                r_acc       <= '0;
                r_digit_cnt <= '0;
                r_idx       <= '0;
              end
              CLS_NUM: begin
                if (r_digit_cnt < CNT_W'(MAX_DIGITS)) begin
                  r_acc       <= w_acc_next;
                  r_digit_cnt <= r_digit_cnt + CNT_W'(1);
                end else begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
                end
              end
              CLS_NULL: begin
                if (w_have_digits) begin
                  if (w_idx_room) begin
                    for (int unsigned i = 0; i < NUM_COORDS; i++)
                      if (r_idx == IDX_W'(i)) r_slots[i] <= r_acc;
                    r_idx       <= r_idx + IDX_W'(1);
                    r_acc       <= '0;
                    r_digit_cnt <= '0;
                  end else begin
                    r_err   <= 1'b1;
                    r_state <= ST_IDLE;
                  end
                end
              end
              default: begin
                if (w_end_ok) begin
                  r_coords <= w_frame;
                  r_valid  <= 1'b1;
                end else begin
                  r_err <= 1'b1;
                end
                r_state <= ST_IDLE;
              end
            endcase
          end
        endcase
      end
    end
  end

  assign bus.coords       = r_coords;
  assign bus.coords_valid = r_valid;
  assign bus.frame_error  = r_err;
  assign bus.busy         = (r_state == ST_RECV);
endmodule

// File: tb/tb_coord_frame_assembler.sv
// Directed character-string bench for coord_frame_assembler with a queue-based
// frame model checked every cycle plus literal spot checks.
module tb_coord_frame_assembler;
  localparam int N   = 3;
  localparam int W   = 10;
  localparam int MAXD = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  coord_frame_assembler_if #(.NUM_COORDS(N), .COORD_W(W)) bus ();

  coord_frame_assembler #(.NUM_COORDS(N), .COORD_W(W), .MAX_DIGITS(MAXD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;
  bit checking = 1'b0;

  // model state
  bit           m_open;
  int           m_vals[$];
  int           m_digits;
  int           m_acc;
  logic [N*W-1:0] exp_coords;
  logic         exp_valid, exp_err;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [N*W-1:0] lit3(input int c2, input int c1, input int c0);
    logic [N*W-1:0] v;
    v = {W'(c2), W'(c1), W'(c0)};
    return v;
  endfunction

  task automatic model_reset();
    m_open = 0; m_vals.delete(); m_digits = 0; m_acc = 0;
    exp_coords = '0; exp_valid = 0; exp_err = 0;
  endtask

  task automatic model_step(input byte c);
    exp_valid = 0;
    exp_err   = 0;
    if (c == "S") begin
      if (m_open) exp_err = 1;
      m_open = 1; m_vals.delete(); m_digits = 0; m_acc = 0;
    end else if (m_open) begin
      if (c >= "0" && c <= "9") begin
        if (m_digits == MAXD) begin exp_err = 1; m_open = 0; end
        else begin m_acc = m_acc * 10 + (c - "0"); m_digits++; end
      end else if (c == "E") begin
        m_open = 0;
        if (m_digits > 0) begin
          if (m_vals.size() == N) exp_err = 1;
          else m_vals.push_back(m_acc);
        end
        if (!exp_err) begin
          if (m_vals.size() == N) begin
            for (int i = 0; i < N; i++) exp_coords[i*W +: W] = W'(m_vals[i]);
            exp_valid = 1;
          end else exp_err = 1;
        end
      end else if (m_digits > 0) begin
        if (m_vals.size() == N) begin exp_err = 1; m_open = 0; end
        else begin m_vals.push_back(m_acc); m_digits = 0; m_acc = 0; end
      end
    end
  endtask

  task automatic send_char(input byte c, input int gap);
    bus.char_valid = 1'b1;
    bus.num        = (c >= "0" && c <= "9") ? 8'(c - "0") : 8'(c);
    bus.coords_state = (c == "S") ? 2'b01 : (c == "E") ? 2'b10 :
                       (c >= "0" && c <= "9") ? 2'b11 : 2'b00;
    @(posedge clock);
    model_step(c);
    #1;
    bus.char_valid = 1'b0;
    bus.num = 8'hA5;
    bus.coords_state = 2'b01;
    for (int g = 0; g < gap; g++) begin
      @(posedge clock);
      exp_valid = 0; exp_err = 0;
      #1;
    end
  endtask

  task automatic send_str(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++)
      send_char(s[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    send_char(" ", 0);
  endtask

  always @(negedge clock) begin
    if (checking) begin
      check("coords",       64'(bus.coords),       64'(exp_coords));
      check("coords_valid", 64'(bus.coords_valid), 64'(exp_valid));
      check("frame_error",  64'(bus.frame_error),  64'(exp_err));
      check("busy",         64'(bus.busy),         64'(m_open));
    end
  end

  initial begin
    bus.char_valid = 1'b0;
    bus.num = '0;
    bus.coords_state = 2'b00;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_coords", 64'(bus.coords), 64'd0);
    check("reset_busy",   64'(bus.busy),   64'd0);
    checking = 1'b1;

    send_str("S120,45,7E", 0);
    check("lit_frame1", 64'(bus.coords), 64'(lit3(7, 45, 120)));
    send_str("S1,,2,3E", 0);
    check("lit_frame2", 64'(bus.coords), 64'(lit3(3, 2, 1)));
    send_str("S 9 8 7E", 0);
    check("lit_frame3", 64'(bus.coords), 64'(lit3(7, 8, 9)));
    send_str("S1234,5,6E", 0);
    check("lit_overflow_hold", 64'(bus.coords), 64'(lit3(7, 8, 9)));
    send_str("S1,2E", 0);
    send_str("S1,2,3,4E", 0);
    check("lit_bad_hold", 64'(bus.coords), 64'(lit3(7, 8, 9)));
    send_str("S5,6S1,2,3E", 0);
    check("lit_restart", 64'(bus.coords), 64'(lit3(3, 2, 1)));
    send_str("S999,0,512E", 0);
    check("lit_max", 64'(bus.coords), 64'(lit3(512, 0, 999)));

    send_str("S120,45,7E", 4);
    send_str("S1234,5,6E", 3);
    send_str("S5,6S1,2,3E", 5);
    check("lit_gaps", 64'(bus.coords), 64'(lit3(3, 2, 1)));

    send_str("S12,3", 2);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    send_str("4,5,6E", 1);
    check("lit_after_reset", 64'(bus.coords), 64'd0);

    repeat (3) @(posedge clock);
    #1 checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
